// File: rtl/tt_sweep_driver.sv
// Truth-table sweeper: drives En/W through all 16 codes, captures {F,G,H} per code. Define TT_SWEEP_GRAY_EN for Gray order.
// Latency: each code held DWELL cycles, sample at end of hold; rd_data is 1-cycle registered read.
// No backpressure: start ignored while not idle, abort stops a sweep without a done pulse.
module tt_sweep_driver #(
  parameter int DWELL = 20,
  parameter int CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic [3:0] w_out,
  output logic       en_out,
  input  logic       f_in,
  input  logic       g_in,
  input  logic       h_in,
  output logic       busy,
  output logic       done,
  input  logic [3:0] rd_addr,
  output logic [2:0] rd_data
);

  typedef enum logic [1:0] {IDLE, DRIVE, FINISH} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]       idx, idx_nxt;
  logic             wr_en;
  logic [2:0]       tt_mem [16];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    wr_en     = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          state_nxt = DRIVE;
          cnt_nxt   = '0;
          idx_nxt   = '0;
        end
      end
      DRIVE: begin
        // abort takes priority over the end-of-hold capture
        if (abort) begin
          state_nxt = IDLE;
        end else if (cnt == LAST) begin
          wr_en   = 1'b1;
          cnt_nxt = '0;
          if (idx == 4'hF) state_nxt = FINISH;
          else             idx_nxt   = idx + 4'd1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef TT_SWEEP_GRAY_EN
  assign w_out = idx ^ (idx >> 1);
`else
  assign w_out = idx;
`endif

  assign busy   = (state == DRIVE);
  assign en_out = (state == DRIVE);
  assign done   = (state == FINISH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) tt_mem[i] <= 3'b000;
      rd_data <= 3'b000;
    end else begin
      if (wr_en) tt_mem[w_out] <= {f_in, g_in, h_in};
      rd_data <= tt_mem[rd_addr];
    end
  end

endmodule

// File: tb/tb_tt_sweep_driver.sv
// Directed bench for tt_sweep_driver with a time-indexed reference model checked every cycle.
module tb_tt_sweep_driver;

`ifdef TT_SWEEP_GRAY_EN
  localparam int DW = 1;
  localparam logic [3:0] SEQ [16] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                                      4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};
`else
  localparam int DW = 4;
  localparam logic [3:0] SEQ [16] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7,
                                      4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15};
`endif

  logic       clk = 1'b0;
  logic       rst_n, start, abort;
  logic [3:0] w_out, rd_addr;
  logic       en_out, f_in, g_in, h_in, busy, done;
  logic [2:0] rd_data;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // ideal function block: F=W[0], G=parity(W), H=AND(W)
  assign f_in = w_out[0];
  assign g_in = ^w_out;
  assign h_in = &w_out;

  tt_sweep_driver #(.DWELL(DW), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .w_out(w_out), .en_out(en_out), .f_in(f_in), .g_in(g_in), .h_in(h_in),
    .busy(busy), .done(done), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] fgh(input logic [3:0] c);
    return {c[0], ^c, &c};
  endfunction

  // reference model: a sweep is "t cycles since start"; code k occupies t in [k*DW, (k+1)*DW)
  logic [2:0] mtbl [16];
  logic       m_active, e_busy, e_done, was_done;
  logic [3:0] e_w;
  logic [2:0] e_rd, nxt_rd;
  int         m_t;
  logic [3:0] prev_w;
  logic       prev_busy;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        for (int i = 0; i < 16; i++) mtbl[i] = 3'b000;
        m_active = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_w = 4'd0; e_rd = 3'b000; m_t = 0;
        prev_busy = 1'b0; prev_w = 4'd0;
        check("rst_w", {28'd0, w_out}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rd", {29'd0, rd_data}, 32'd0);
      end else begin
        check("w_out", {28'd0, w_out}, {28'd0, e_w});
        check("busy", {31'd0, busy}, {31'd0, e_busy});
        check("en_out", {31'd0, en_out}, {31'd0, e_busy});
        check("done", {31'd0, done}, {31'd0, e_done});
        check("rd_data", {29'd0, rd_data}, {29'd0, e_rd});
        if (busy && prev_busy && w_out != prev_w) begin
`ifdef TT_SWEEP_GRAY_EN
          check("gray_step", $countones(w_out ^ prev_w), 32'd1);
`else
          check("bin_step", {28'd0, w_out}, {28'd0, prev_w + 4'd1});
`endif
        end
        prev_w = w_out;
        prev_busy = busy;
        // predict the state after the coming edge from the inputs it will sample
        nxt_rd = mtbl[rd_addr];
        was_done = e_done;
        e_done = 1'b0;
        if (m_active) begin
          if (abort) begin
            m_active = 1'b0; e_busy = 1'b0;
          end else begin
            if (m_t % DW == DW - 1) mtbl[SEQ[m_t / DW]] = fgh(SEQ[m_t / DW]);
            m_t++;
            if (m_t == 16 * DW) begin
              m_active = 1'b0; e_busy = 1'b0; e_done = 1'b1;
            end else begin
              e_w = SEQ[m_t / DW];
            end
          end
        end else if (!was_done && start && !abort) begin
          m_active = 1'b1; e_busy = 1'b1; m_t = 0; e_w = SEQ[0];
        end
        e_rd = nxt_rd;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_w(input logic [3:0] v);
    for (int i = 0; i < 300; i++) begin
      if (busy && w_out == v) return;
      tick();
    end
    check("wait_w_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 300; i++) begin
      if (done) return;
      tick();
    end
    check("wait_done_timeout", 32'd0, 32'd1);
  endtask

  task automatic read_chk(input logic [3:0] a, input logic [2:0] exp, input string name);
    rd_addr = a;
    tick();
    check(name, {29'd0, rd_data}, {29'd0, exp});
  endtask

  task automatic readback_all();
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i);
      tick();
    end
    tick();
  endtask

  initial begin
    int  busy_cnt;
    bit  seen_done;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; rd_addr = 4'd0;
    repeat (3) tick();
    rst_n = 1'b1;
    check("reset_w_out", {28'd0, w_out}, 32'd0);
    check("reset_en", {31'd0, en_out}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);

    // abort at code 6 on a freshly reset table
    start = 1'b1; tick(); start = 1'b0;
    wait_w(4'd6);
    abort = 1'b1; tick(); abort = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_en", {31'd0, en_out}, 32'd0);
    check("abort_w_hold", {28'd0, w_out}, 32'd6);
    repeat (3) tick();
`ifdef TT_SWEEP_GRAY_EN
    read_chk(4'd2, 3'b010, "abort_entry2");
    read_chk(4'd5, 3'b000, "abort_entry5");
`else
    read_chk(4'd5, 3'b100, "abort_entry5");
    read_chk(4'd0, 3'b000, "abort_entry0");
`endif
    read_chk(4'd6, 3'b000, "abort_entry6");
    read_chk(4'd15, 3'b000, "abort_entry15");
    readback_all();

    // full sweep after reset
    rst_n = 1'b0; tick(); tick(); rst_n = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    busy_cnt = 0; seen_done = 1'b0;
    for (int i = 0; i < 16 * DW + 20; i++) begin
      if (busy) busy_cnt++;
      if (done) begin seen_done = 1'b1; break; end
      tick();
    end
    check("busy_cycles", busy_cnt, 16 * DW);
    check("done_seen", {31'd0, seen_done}, 32'd1);
    check("done_en_low", {31'd0, en_out}, 32'd0);
    tick();
    check("done_one_cycle", {31'd0, done}, 32'd0);
`ifdef TT_SWEEP_GRAY_EN
    check("final_w", {28'd0, w_out}, 32'd8);
`else
    check("final_w", {28'd0, w_out}, 32'd15);
`endif
    read_chk(4'd5, 3'b100, "read5");
    read_chk(4'd15, 3'b101, "read15");
    read_chk(4'd0, 3'b000, "read0");
    readback_all();

    // start while busy must not restart the sequence
    start = 1'b1; tick(); start = 1'b0;
    wait_w(4'd3);
    start = 1'b1; tick(); start = 1'b0;
    wait_done();
    tick();
    // simultaneous start+abort in idle
    start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    check("start_abort_busy", {31'd0, busy}, 32'd0);
    tick();
    check("start_abort_busy2", {31'd0, busy}, 32'd0);

    // asynchronous reset between edges
    start = 1'b1; tick(); start = 1'b0;
    wait_w(4'd9);
    #1 rst_n = 1'b0;
    #1;
    check("areset_w", {28'd0, w_out}, 32'd0);
    check("areset_busy", {31'd0, busy}, 32'd0);
    check("areset_en", {31'd0, en_out}, 32'd0);
    check("areset_rd", {29'd0, rd_data}, 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) read_chk(4'(i), 3'b000, "areset_tbl");
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tt_sweep_driver.md
Name: tt_sweep_driver

Overview:
- Upstream stimulus and capture stage for the 4-input enable-gated function block (inputs En, W[3:0]; outputs F, G, H).
- On a start pulse, drives En high and walks W through all 16 codes, holding each code for a programmable number of clock cycles.
- Samples F/G/H at the end of each hold and stores the results in a 16-entry x 3-bit truth-table memory, readable after the sweep.
- Replaces hand-written per-code delay stimulus with a synthesizable, self-timed sweeper.

Parameters:
- DWELL, 20, clock cycles each code is held on w_out; legal range 1..255.
- CNT_W, 8, width of the internal dwell counter; must satisfy 2^CNT_W > DWELL.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  single-cycle request to begin a sweep
- abort  input  1  terminate an in-progress sweep
- w_out  output  4  code driven to the function block's W input
- en_out  output  1  drive to the function block's En input
- f_in  input  1  F result from the function block
- g_in  input  1  G result from the function block
- h_in  input  1  H result from the function block
- busy  output  1  sweep in progress
- done  output  1  one-cycle pulse when a full sweep completes
- rd_addr  input  4  truth-table read index
- rd_data  output  3  {F,G,H} stored for code rd_addr, registered

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values:
  - w_out=0, en_out=0, busy=0, done=0, rd_data=0.
  - All 16 table entries = 3'b000.
  - FSM in IDLE, dwell counter = 0.
- FSM states: IDLE, DRIVE, FINISH.
- IDLE:
  - start=1 and abort=0 at an edge -> DRIVE. At that edge: w_out=0, en_out=1, busy=1, counter=0.
  - start is ignored outside IDLE.
- DRIVE:
  - The counter increments each cycle.
  - When counter==DWELL-1, at that edge the table entry [w_out] <= {f_in,g_in,h_in}, then:
    - if w_out==15 -> FINISH, with en_out=0 and busy=0;
    - otherwise w_out <= w_out+1 and counter <= 0.
  - Each code is therefore held exactly DWELL cycles.
  - busy is high for exactly 16*DWELL cycles.
- FINISH:
  - done=1 for exactly one cycle, then -> IDLE.
  - w_out holds 15 until the next start.
- Abort:
  - abort=1 in DRIVE -> IDLE at the next edge, with en_out=0 and busy=0.
  - done is not pulsed; w_out holds its last value.
  - Entries already written are retained; unwritten entries keep their previous contents.
  - abort in IDLE or FINISH has no effect; FINISH still pulses done.
  - start and abort in the same IDLE cycle: abort wins, no sweep starts.
- Read port:
  - rd_data <= table[rd_addr] on every edge (1-cycle latency), regardless of state.
  - A read of the entry being written in the same cycle returns the old value.
- Wrap:
  - w_out never increments past 15; no modular wrap within a sweep.
  - A new start restarts at code 0 and overwrites entries in order.
- Reset mid-sweep: all outputs and the table return to reset values immediately (asynchronously).

Optional Feature:
- Macro: TT_SWEEP_GRAY_EN.
- When defined:
  - An internal binary index 0..15 still sequences the sweep, but w_out = index ^ (index>>1) (Gray order 0,1,3,2,6,...,8).
  - Only one W bit changes per step.
  - Table entries are still written at address w_out, so the table stays indexed by code value.
  - The sweep terminates after index 15, which is code 8.
  - After FINISH, w_out holds 8.
- When undefined: w_out = index (binary order 0..15).

Test Plan:
- Reset and ideal sweep: DWELL=4; assert rst_n low then high; drive f_in=w_out[0], g_in=^w_out, h_in=&w_out; pulse start.
  - Required response: busy high for 64 cycles, done high exactly 1 cycle after.
  - Reads: rd_addr=5 -> rd_data=3'b100; rd_addr=15 -> 3'b101; rd_addr=0 -> 3'b000.
- Dwell timing: DWELL=4.
  - Required response: w_out changes every 4 cycles; en_out=1 exactly while busy=1; en_out=0 in the done cycle.
- Abort: DWELL=4; abort while w_out=6.
  - Required response: busy=0 and en_out=0 next cycle; no done pulse.
  - Entries 0..5 are written; entry 6 and above still read 3'b000 (from reset).
- Start while busy and start+abort in IDLE.
  - Required response: no restart or change in w_out sequence; simultaneous start+abort leaves busy=0.
- Asynchronous reset mid-sweep: drop rst_n at w_out=9 between clock edges.
  - Required response: outputs clear without a clock edge; table reads all 0 afterwards.
- TT_SWEEP_GRAY_EN defined, DWELL=1.
  - Required response: w_out sequence 0,1,3,2,6,7,5,4,12,13,15,14,10,11,9,8; Hamming distance between successive codes = 1.
  - Table readback identical to the binary run.
